// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them sequentially from address 0 while holding the core.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t          state;
  logic [ADDR_W:0] count;
  logic [1:0]      idx;
  logic            count_ok;
  logic            last_word;

  assign count_ok  = (word_count != '0) && (word_count <= MAX_COUNT);
  assign last_word = ({1'b0, mem_addr} == (count - ONE));

  // mem_addr doubles as the address counter and mem_wdata as the assembly
  // register; both hold still through WRITE since no byte is accepted there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      idx        <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count_ok) begin
              count      <= word_count;
              err        <= 1'b0;
              mem_addr   <= '0;
              idx        <= '0;
              state      <= LOAD;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (byte_valid) begin
            mem_wdata[{idx, 3'b000} +: 8] <= byte_in;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
            end
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          if (last_word) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            mem_addr   <= mem_addr + ADDR_W'(1);
            state      <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the single-word load and
// reject cases, then hand sequences for multi-word, gapped, reset and full loads.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [8:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, busy, cpu_hold, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, start;
    logic [8:0]  wc;
    logic        bv;
    logic [7:0]  b;
    logic        e_br, e_we, e_busy, e_hold, e_done, e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          overlap  = 0;
  int          busy_drop;
  logic [7:0]  prog [0:1023];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
    if (mem_we && byte_ready) overlap++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, s, input int wc, input logic bv, input logic [7:0] b,
                     input logic br, we, bs, hd, dn, er, input logic [31:0] d);
    vec_t v;
    v.rst = r; v.start = s; v.wc = 9'(wc); v.bv = bv; v.b = b;
    v.e_br = br; v.e_we = we; v.e_busy = bs; v.e_hold = hd; v.e_done = dn; v.e_err = er;
    v.e_data = d;
    vecs.push_back(v);
  endtask

  task automatic start_load(input int wc);
    start = 1'b1; word_count = 9'(wc);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_accepted", {31'b0, byte_ready}, 1);
  endtask

  // Feed prog[first .. first+nb-1]; with gap, byte_valid is high every other cycle.
  task automatic feed(input int first, input int nb, input bit gap);
    int  i = first;
    int  cyc = 0;
    bit  acc;
    while (i < first + nb && cyc < 20 * nb + 20) begin
      byte_valid = gap ? (cyc % 2 == 0) : 1'b1;
      byte_in    = byte_valid ? prog[i] : 8'hEE;
      acc        = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) i++;
      if (!busy) busy_drop++;
      cyc++;
    end
    byte_valid = 1'b0;
    chk("feed_complete", i, first + nb);
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_done"}, {31'b0, done}, 1);
    @(posedge clk); #1;
    chk({name, "_done_width"}, {31'b0, done}, 0);
    chk({name, "_hold_released"}, {31'b0, cpu_hold}, 0);
    chk({name, "_idle_busy"}, {31'b0, busy}, 0);
  endtask

  task automatic check_writes(input string name, input int n);
    chk({name, "_write_count"}, wr_addr.size(), n);
    for (int k = 0; k < n && k < wr_addr.size(); k++) begin
      chk($sformatf("%s_addr%0d", name, k), {24'b0, wr_addr[k]}, k);
      chk($sformatf("%s_data%0d", name, k), wr_data[k],
          {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    busy_drop = 0;

    // rst start wc bv byte | ready we busy hold done err | data
    add(1, 0,   0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 1,   0, 0, 8'h00,  0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 1, 257, 0, 8'h00,  0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0,   0, 1, 8'h55,  0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 1,   1, 0, 8'h00,  1, 0, 1, 1, 0, 0, 32'h0);
    add(0, 1,   0, 0, 8'h00,  1, 0, 1, 1, 0, 0, 32'h0);
    add(0, 0,   1, 1, 8'h13,  1, 0, 1, 1, 0, 0, 32'h0);
    add(0, 0,   1, 1, 8'h00,  1, 0, 1, 1, 0, 0, 32'h0);
    add(0, 0,   1, 1, 8'h00,  1, 0, 1, 1, 0, 0, 32'h0);
    add(0, 0,   1, 1, 8'h00,  0, 1, 1, 1, 0, 0, 32'h00000013);
    add(0, 0,   1, 0, 8'h00,  0, 0, 0, 1, 1, 0, 32'h0);
    add(0, 0,   1, 0, 8'h00,  0, 0, 0, 0, 0, 0, 32'h0);

    @(posedge clk); #1;
    for (int r = 0; r < vecs.size(); r++) begin
      rst = vecs[r].rst; start = vecs[r].start; word_count = vecs[r].wc;
      byte_valid = vecs[r].bv; byte_in = vecs[r].b;
      @(posedge clk); #1;
      chk($sformatf("row%0d_byte_ready", r), {31'b0, byte_ready}, {31'b0, vecs[r].e_br});
      chk($sformatf("row%0d_mem_we", r),     {31'b0, mem_we},     {31'b0, vecs[r].e_we});
      chk($sformatf("row%0d_busy", r),       {31'b0, busy},       {31'b0, vecs[r].e_busy});
      chk($sformatf("row%0d_cpu_hold", r),   {31'b0, cpu_hold},   {31'b0, vecs[r].e_hold});
      chk($sformatf("row%0d_done", r),       {31'b0, done},       {31'b0, vecs[r].e_done});
      chk($sformatf("row%0d_err", r),        {31'b0, err},        {31'b0, vecs[r].e_err});
      if (vecs[r].e_we) begin
        chk($sformatf("row%0d_mem_addr", r), {24'b0, mem_addr}, 32'h0);
        chk($sformatf("row%0d_mem_wdata", r), mem_wdata, vecs[r].e_data);
      end
    end
    start = 1'b0; byte_valid = 1'b0;
    chk("table_single_write", wr_addr.size(), 1);
    chk("table_done_count", done_cnt, 1);

    // Two-word program in order
    {prog[0], prog[1], prog[2], prog[3]} = {8'hB3, 8'h00, 8'h50, 8'h00};
    {prog[4], prog[5], prog[6], prog[7]} = {8'h93, 8'h80, 8'h10, 8'h00};
    wr_addr.delete(); wr_data.delete(); done_cnt = 0;
    start_load(2);
    feed(0, 8, 1'b0);
    wait_done("two_word");
    check_writes("two_word", 2);
    chk("two_word_data0_literal", wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h005000B3);
    chk("two_word_data1_literal", wr_data.size() > 1 ? wr_data[1] : 32'hx, 32'h00108093);

    // Three words with byte_valid gaps
    for (int i = 0; i < 12; i++) prog[i] = 8'(8'h11 * (i + 1) + 3);
    wr_addr.delete(); wr_data.delete(); busy_drop = 0;
    start_load(3);
    feed(0, 12, 1'b1);
    chk("gapped_busy_held", busy_drop, 0);
    wait_done("gapped");
    check_writes("gapped", 3);

    // Illegal start sets err, reset clears it
    start = 1'b1; word_count = 9'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("illegal_err_set", {31'b0, err}, 1);
    chk("illegal_stays_idle", {31'b0, busy}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_clears_err", {31'b0, err}, 0);

    // Reset in the middle of the second word, with start and byte_valid also high
    {prog[0], prog[1], prog[2], prog[3]} = {8'hB3, 8'h00, 8'h50, 8'h00};
    {prog[4], prog[5], prog[6], prog[7]} = {8'h93, 8'h80, 8'h10, 8'h00};
    wr_addr.delete(); wr_data.delete(); done_cnt = 0;
    start_load(2);
    feed(0, 6, 1'b0);
    rst = 1'b1; start = 1'b1; word_count = 9'd1; byte_valid = 1'b1; byte_in = 8'hAA;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    chk("rst_byte_ready", {31'b0, byte_ready}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_still_idle", {31'b0, busy}, 0);
    check_writes("rst_mid", 1);
    chk("rst_no_done", done_cnt, 0);
    wr_addr.delete(); wr_data.delete();
    start_load(1);
    feed(0, 4, 1'b0);
    wait_done("after_rst");
    check_writes("after_rst", 1);

    // Full-depth load
    for (int i = 0; i < 1024; i++) prog[i] = 8'($urandom_range(0, 255));
    wr_addr.delete(); wr_data.delete(); done_cnt = 0;
    start_load(256);
    feed(0, 1024, 1'b0);
    wait_done("full");
    repeat (4) @(posedge clk);
    #1;
    check_writes("full", 256);
    chk("full_done_once", done_cnt, 1);
    chk("we_while_ready", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 8, word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 start  input  1  load request; sampled only in IDLE.
REQ-006 word_count  input  ADDR_W+1  number of words to load; latched on accepted start.
REQ-007 byte_in  input  8  program byte stream, little-endian within each word.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 mem_addr  output  ADDR_W  word address of the write.
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  load in progress.
REQ-014 cpu_hold  output  1  holds the fetch stage/core in reset while memory is rewritten.
REQ-015 done  output  1  one-cycle pulse after the last word is written.
REQ-016 err  output  1  sticky flag: illegal word_count on last start.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: byte_ready=0, mem_we=0, busy=0, cpu_hold=0; start ignored in any other state.
REQ-019 IDLE, start=1, word_count in 1..DEPTH: latch count, clear err, word address=0, byte index=0, go LOAD next cycle.
REQ-020 IDLE, start=1, word_count=0 or >DEPTH: set err=1, remain IDLE, no write issued.
REQ-021 LOAD: byte_ready=1, busy=1, cpu_hold=1; byte accepted only when byte_valid and byte_ready both high.
REQ-022 Accepted byte k (0..3) SHALL be placed in word bits [8k+7:8k]; byte_valid low stalls without state change.
REQ-023 4th accepted byte: go WRITE next cycle; byte index wraps to 0.
REQ-024 WRITE (exactly one cycle): mem_we=1, mem_addr=current address, mem_wdata=assembled word, byte_ready=0, cpu_hold=1.
REQ-025 After WRITE: if address = count-1 go DONE, else address+1 and go LOAD.
REQ-026 DONE (one cycle): done=1, busy=0, cpu_hold=1; next state IDLE, where cpu_hold drops.
REQ-027 Minimum throughput: 5 cycles per word (4 LOAD + 1 WRITE); no write while byte_ready=1.
REQ-028 word_count=DEPTH SHALL write addresses 0..DEPTH-1 with no address wrap and no write beyond DEPTH-1.
REQ-029 mem_addr and mem_wdata SHALL be stable whenever mem_we=1; their value when mem_we=0 is don't-care.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, byte_ready=0, mem_we=0, busy=0, cpu_hold=0, done=0, err=0, address=0, byte index=0.
REQ-031 rst mid-load SHALL discard partial bytes and issue no further write; words already written remain in memory.
REQ-032 rst has priority over start and byte_valid in the same cycle.

Verification
REQ-033 word_count=1, bytes 13,00,00,00 back-to-back -> one mem_we at addr 0, data 0x00000013, done pulse 1 cycle after write, cpu_hold low next cycle.
REQ-034 word_count=2, bytes B3,00,50,00,93,80,10,00 -> writes 0x005000B3 @0 and 0x00108093 @1, in order, only these two writes.
REQ-035 word_count=3 with byte_valid toggled every other cycle -> same word data as gap-free run, no extra mem_we, busy high throughout.
REQ-036 word_count=0 then 257 -> err=1, no mem_we, state IDLE; next legal start clears err.
REQ-037 rst asserted after 2 bytes of word 1 -> no write at addr 1, all outputs at reset values next cycle; new load restarts at addr 0.
REQ-038 word_count=256 random bytes -> 256 writes, addresses 0..255 increasing, final data matches scoreboard, done once.
